// File: rtl/keypad_event_ctrl_if.sv
// Keypad event controller bus: scanner reports and FIFO/keyboard read side.
// The master modport is the scanner/CPU side, the slave modport is the controller.
interface keypad_event_ctrl_if #(
    parameter int DEPTH = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [3:0]    key_index;
    logic          key_valid;
    logic          key_down;
    logic          enable;
    logic          rd_en;
    logic          clr_ovf;
    logic [15:0]   rd_data;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;
    logic          overflow;
    logic [15:0]   kbd;

    modport master (
        output key_index, key_valid, key_down, enable, rd_en, clr_ovf,
        input  rd_data, empty, full, count, overflow, kbd
    );

    modport slave (
        input  key_index, key_valid, key_down, enable, rd_en, clr_ovf,
        output rd_data, empty, full, count, overflow, kbd
    );
endinterface

// File: rtl/keypad_event_ctrl.sv
// Keypad event controller: turns scanner press reports into a buffered ASCII event
// stream with typematic auto-repeat, plus a Hack-style level keyboard register.
module keypad_event_ctrl #(
    parameter int          DEPTH         = 8,
    parameter logic [23:0] REPEAT_DELAY  = 24'd500000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd100000
) (
    input logic                 clk,
    input logic                 rst_n,
    keypad_event_ctrl_if.slave  bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic logic [7:0] to_ascii(input logic [3:0] idx);
        return (idx < 4'd10) ? (8'h30 + {4'b0000, idx}) : (8'h37 + {4'b0000, idx});
    endfunction

    logic [1:0]    state, state_next;
    logic [23:0]   cnt, cnt_next, limit_m1;
    logic [3:0]    held_idx, held_idx_next;
    logic          push;
    logic [8:0]    push_entry;

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          overflow;
    logic          empty, full, pop, do_write, drop;

    assign limit_m1 = ((state == ST_DELAY) ? REPEAT_DELAY : REPEAT_PERIOD) - 24'd1;

    // A new press always wins, even with the key already released in the same cycle.
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        held_idx_next = held_idx;
        push          = 1'b0;
        push_entry    = '0;
        if (!bus.enable) begin
            state_next = ST_IDLE;
            cnt_next   = '0;
        end else if (bus.key_valid) begin
            push          = 1'b1;
            push_entry    = {1'b0, to_ascii(bus.key_index)};
            held_idx_next = bus.key_index;
            state_next    = ST_DELAY;
            cnt_next      = '0;
        end else if (state != ST_IDLE) begin
            if (!bus.key_down) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end else if (cnt == limit_m1) begin
                push       = 1'b1;
                push_entry = {1'b1, to_ascii(held_idx)};
                state_next = ST_REPEAT;
                cnt_next   = '0;
            end else begin
                cnt_next = cnt + 24'd1;
            end
        end
    end

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign pop      = bus.rd_en && !empty;
    // A simultaneous pop frees the slot, so a full FIFO still accepts the push.
    assign do_write = push && (!full || pop);
    assign drop     = push && full && !pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            held_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            held_idx <= held_idx_next;
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (do_write && !pop)      count <= count + 1'b1;
            else if (!do_write && pop) count <= count - 1'b1;
            if (drop)             overflow <= 1'b1;
            else if (bus.clr_ovf) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && do_write) mem[wr_ptr] <= push_entry;
    end

    assign bus.rd_data  = empty ? 16'h0000 : {7'b0000000, mem[rd_ptr]};
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.count    = count;
    assign bus.overflow = overflow;
    assign bus.kbd      = (state != ST_IDLE) ? {8'h00, to_ascii(held_idx)} : 16'h0000;
endmodule
